xadc_multi_channel: RTL and testbench

Parametrised successor to the single-channel XADC display path. It sequences DRP reads of NUM_CH auxiliary XADC channels in round-robin order and keeps a per-channel boxcar average of 2^AVG_LOG2 samples. It scales the selected channel to millivolts and presents one mux-selected 16-bit word to the seven-segment or LED path. It sits between the XADC IP (continuous mode, DRP port) and the display driver.

---
 rtl/xadc_multi_channel_if.sv | 24 ++
 rtl/xadc_multi_channel.sv | 220 ++++++++++++++++++++++
 tb/tb_xadc_multi_channel.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/xadc_multi_channel_if.sv
// DRP read channel plus end-of-conversion strobe between the XADC IP (slave) and the sequencer (master).
interface xadc_multi_channel_if;
    logic        eoc_in;
    logic        drp_den;
    logic [6:0]  drp_daddr;
    logic        drp_drdy;
    logic [15:0] drp_do;

    modport master (
        input  eoc_in,
        output drp_den,
        output drp_daddr,
        input  drp_drdy,
        input  drp_do
    );

    modport slave (
        output eoc_in,
        input  drp_den,
        input  drp_daddr,
        output drp_drdy,
        output drp_do
    );
endinterface

// File: rtl/xadc_multi_channel.sv
// Round-robin XADC DRP reader with per-channel boxcar averaging, mV scaling and a display mux.
// Optional macro XADC_BCD_OUT_EN: mode 3 shows the mV value as 4 BCD digits instead of a status word.
module xadc_multi_channel #(
    parameter int         NUM_CH    = 4,
    parameter logic [6:0] BASE_ADDR = 7'h1C,
    parameter int         AVG_LOG2  = 4,
    parameter int         TIMEOUT   = 255,
    localparam int        CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    xadc_multi_channel_if.master drp,
    input  logic [CH_W-1:0]      ch_select,
    input  logic [1:0]           mode_select,
    output logic [15:0]          data_out,
    output logic                 data_valid,
    output logic [NUM_CH-1:0]    ch_ready,
    output logic                 timeout_err
);

    localparam int ACC_W  = 12 + AVG_LOG2;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_ACCUM,
        S_NEXT
    } state_t;

    state_t              r_state;
    logic [CH_W-1:0]     r_ch_idx;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_den;
    logic [6:0]          r_daddr;
    logic                r_timeout_err;
    logic [NUM_CH-1:0]   r_ch_ready;
    logic [11:0]         r_raw [NUM_CH];
    logic [ACC_W-1:0]    r_acc [NUM_CH];
    logic [AVG_LOG2-1:0] r_cnt [NUM_CH];
    logic [15:0]         r_avg [NUM_CH];
    logic                r_upd;
    logic [15:0]         r_data_out;
    logic                r_data_valid;

    logic [ACC_W-1:0]    w_acc_sum;
    logic                w_cnt_wrap;
    logic                w_sel_ok;
    logic [CH_W-1:0]     w_sel_idx;
    logic [15:0]         w_avg_sel;
    logic [25:0]         w_prod;
    logic [15:0]         w_mv;
    logic                w_avg_upd;
    logic [15:0]         w_mux;

    assign w_acc_sum  = r_acc[r_ch_idx] + ACC_W'(r_raw[r_ch_idx]);
    assign w_cnt_wrap = (r_cnt[r_ch_idx] == '1);
    assign w_sel_ok   = (32'(ch_select) < 32'(NUM_CH));
    assign w_sel_idx  = w_sel_ok ? ch_select : '0;
    assign w_avg_sel  = r_avg[w_sel_idx];
    // 1 V full scale: avg is a 16-bit fraction of full scale, so mV = avg*1000/65536.
    assign w_prod     = 26'(w_avg_sel) * 26'd1000;
    assign w_mv       = 16'(w_prod >> 16);
    assign w_avg_upd  = (r_state == S_ACCUM) && w_cnt_wrap && w_sel_ok && (r_ch_idx == ch_select);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_ch_idx      <= '0;
            r_wait_cnt    <= '0;
            r_den         <= 1'b0;
            r_daddr       <= BASE_ADDR;
            r_timeout_err <= 1'b0;
            r_ch_ready    <= '0;
            // NOTE: the per-channel arrays are reset explicitly so a reset discards partial averages; they stay in flops, not RAM.
            for (int i = 0; i < NUM_CH; i++) begin
                r_raw[i] <= '0;
                r_acc[i] <= '0;
                r_cnt[i] <= '0;
                r_avg[i] <= '0;
            end
        end else begin
            r_den <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (drp.eoc_in) begin
                        r_den   <= 1'b1;
                        r_daddr <= BASE_ADDR + 7'(r_ch_idx);
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (drp.drp_drdy) begin
                        r_raw[r_ch_idx] <= 12'(drp.drp_do >> 4);
                        r_state         <= S_ACCUM;
                    end else if (r_wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_NEXT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_ACCUM: begin
                    r_cnt[r_ch_idx] <= r_cnt[r_ch_idx] + 1'b1;
                    if (w_cnt_wrap) begin
                        r_avg[r_ch_idx]      <= 16'(w_acc_sum >> (AVG_LOG2 - 4));
                        r_acc[r_ch_idx]      <= '0;
                        r_ch_ready[r_ch_idx] <= 1'b1;
                    end else begin
                        r_acc[r_ch_idx] <= w_acc_sum;
                    end
                    r_state <= S_NEXT;
                end
                S_NEXT: begin
                    r_ch_idx <= (r_ch_idx == CH_W'(NUM_CH - 1)) ? '0 : r_ch_idx + 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef XADC_BCD_OUT_EN
    logic [15:0] r_mv_last;
    logic [15:0] r_bcd_sh;
    logic [15:0] r_bcd_acc;
    logic [15:0] r_bcd;
    logic [4:0]  r_bcd_cnt;
    logic        r_bcd_busy;
    logic        r_bcd_done;
    logic        r_bcd_pend;
    logic [15:0] w_bcd_adj;

    always_comb begin
        w_bcd_adj = r_bcd_acc;
        for (int d = 0; d < 4; d++) begin
            if (r_bcd_acc[4*d +: 4] >= 4'd5) w_bcd_adj[4*d +: 4] = r_bcd_acc[4*d +: 4] + 4'd3;
        end
    end

    // Double-dabble: 16 add-3/shift steps; any new mV (or fresh average) restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mv_last  <= '0;
            r_bcd_sh   <= '0;
            r_bcd_acc  <= '0;
            r_bcd      <= '0;
            r_bcd_cnt  <= '0;
            r_bcd_busy <= 1'b0;
            r_bcd_done <= 1'b0;
            r_bcd_pend <= 1'b0;
        end else begin
            r_mv_last  <= w_mv;
            r_bcd_done <= 1'b0;
            if (r_upd) r_bcd_pend <= 1'b1;
            else if (r_bcd_done) r_bcd_pend <= 1'b0;
            if ((w_mv != r_mv_last) || r_upd) begin
                r_bcd_busy <= 1'b1;
                r_bcd_cnt  <= '0;
                r_bcd_sh   <= w_mv;
                r_bcd_acc  <= '0;
            end else if (r_bcd_busy) begin
                r_bcd_acc <= 16'({w_bcd_adj, r_bcd_sh[15]});
                r_bcd_sh  <= 16'({r_bcd_sh, 1'b0});
                r_bcd_cnt <= r_bcd_cnt + 1'b1;
                if (r_bcd_cnt == 5'd15) begin
                    r_bcd_busy <= 1'b0;
                    r_bcd      <= 16'({w_bcd_adj, r_bcd_sh[15]});
                    r_bcd_done <= 1'b1;
                end
            end
        end
    end
`endif

    always_comb begin
        w_mux = '0;
        if (w_sel_ok) begin
            case (mode_select)
                2'd0:    w_mux = w_mv;
                2'd1:    w_mux = {4'h0, r_raw[w_sel_idx]};
                2'd2:    w_mux = w_avg_sel;
`ifdef XADC_BCD_OUT_EN
                default: w_mux = r_bcd;
`else
                default: w_mux = {r_timeout_err, 3'b000, 4'(ch_select), 8'(r_ch_ready)};
`endif
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_upd        <= 1'b0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_upd      <= w_avg_upd;
            r_data_out <= w_mux;
`ifdef XADC_BCD_OUT_EN
            r_data_valid <= (mode_select == 2'd3) ? (r_bcd_done && r_bcd_pend) : r_upd;
`else
            r_data_valid <= r_upd;
`endif
        end
    end

    assign drp.drp_den   = r_den;
    assign drp.drp_daddr = r_daddr;
    assign data_out      = r_data_out;
    assign data_valid    = r_data_valid;
    assign ch_ready      = r_ch_ready;
    assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_xadc_multi_channel.sv
// Directed bench for xadc_multi_channel at default parameters (4 channels, 16-sample average, 255-cycle timeout).
module tb_xadc_multi_channel;

    logic        clk;
    logic        reset;
    logic [1:0]  ch_select;
    logic [1:0]  mode_select;
    logic [15:0] data_out;
    logic        data_valid;
    logic [3:0]  ch_ready;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;
    int valid_cnt = 0;
    int den_cnt   = 0;

    xadc_multi_channel_if bus ();

    xadc_multi_channel dut (
        .clk         (clk),
        .reset       (reset),
        .drp         (bus),
        .ch_select   (ch_select),
        .mode_select (mode_select),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .ch_ready    (ch_ready),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid === 1'b1) valid_cnt++;
        if (bus.drp_den === 1'b1) den_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One eoc -> den -> drdy transaction; checks address and one-cycle den.
    task automatic do_sample(input logic [15:0] val, input logic [6:0] exp_addr);
        bit seen;
        bus.eoc_in = 1'b1;
        step(1);
        bus.eoc_in = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (bus.drp_den === 1'b1) seen = 1'b1;
            else step(1);
        end
        check("den_seen", 32'(seen), 32'd1);
        check("daddr", 32'(bus.drp_daddr), 32'(exp_addr));
        step(1);
        check("den_width", 32'(bus.drp_den), 32'd0);
        bus.drp_drdy = 1'b1;
        bus.drp_do   = val;
        step(1);
        bus.drp_drdy = 1'b0;
        bus.drp_do   = 16'h0000;
        step(3);
    endtask

    task automatic feed_round(input logic [15:0] v0, input logic [15:0] v1,
                              input logic [15:0] v2, input logic [15:0] v3);
        logic [15:0] v [4];
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        for (int c = 0; c < 4; c++) do_sample(v[c], 7'h1C + 7'(c));
    endtask

    initial begin
        int v_base;
        int d_base;
        bit bcd_seen;

        reset         = 1'b1;
        bus.eoc_in    = 1'b0;
        bus.drp_drdy  = 1'b0;
        bus.drp_do    = 16'h0000;
        ch_select     = 2'd0;
        mode_select   = 2'd2;
        step(3);
        check("rst_den", 32'(bus.drp_den), 32'd0);
        check("rst_daddr", 32'(bus.drp_daddr), 32'h1C);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_ready", 32'(ch_ready), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        step(1);

        // 16 rounds: ch0 full scale, ch1 half, ch2 quarter, ch3 zero
        for (int r = 0; r < 15; r++) feed_round(16'hFFF0, 16'h8000, 16'h4000, 16'h0000);
        check("ready_before_16", 32'(ch_ready), 32'd0);
        check("valid_before_16", 32'(valid_cnt), 32'd0);
        feed_round(16'hFFF0, 16'h8000, 16'h4000, 16'h0000);
        check("ch0_avg", 32'(data_out), 32'hFFF0);
        check("ready_after_16", 32'(ch_ready), 32'hF);
        check("valid_once", 32'(valid_cnt), 32'd1);

        mode_select = 2'd0; step(2);
        check("ch0_mv", 32'(data_out), 32'd999);
        mode_select = 2'd1; step(2);
        check("ch0_raw", 32'(data_out), 32'h0FFF);
        ch_select = 2'd1; mode_select = 2'd0; step(2);
        check("ch1_mv", 32'(data_out), 32'd500);
        mode_select = 2'd2; step(2);
        check("ch1_avg", 32'(data_out), 32'h8000);
        ch_select = 2'd2; mode_select = 2'd0; step(2);
        check("ch2_mv", 32'(data_out), 32'd250);
        ch_select = 2'd3; step(2);
        check("ch3_mv", 32'(data_out), 32'd0);
        ch_select = 2'd1; mode_select = 2'd3;
`ifdef XADC_BCD_OUT_EN
        bcd_seen = 1'b0;
        for (int i = 0; i < 40 && !bcd_seen; i++) begin
            step(1);
            if (data_out === 16'h0500) bcd_seen = 1'b1;
        end
        check("ch1_bcd", 32'(data_out), 32'h0500);
`else
        bcd_seen = 1'b0;
        step(2);
        check("status_word", 32'(data_out), 32'h010F);
`endif
        check("no_valid_on_select", 32'(valid_cnt), 32'd1);

        // Timeout on ch0: drdy withheld, extra eoc during WAIT, then a late drdy
        ch_select = 2'd1; mode_select = 2'd1;
        bus.eoc_in = 1'b1;
        step(1);
        bus.eoc_in = 1'b0;
        check("to_den", 32'(bus.drp_den), 32'd1);
        check("to_daddr", 32'(bus.drp_daddr), 32'h1C);
        step(5);
        d_base = den_cnt;
        bus.eoc_in = 1'b1;
        step(1);
        bus.eoc_in = 1'b0;
        step(240);
        check("to_not_yet", 32'(timeout_err), 32'd0);
        check("eoc_in_wait_ignored", 32'(den_cnt), 32'(d_base));
        step(20);
        check("to_flag", 32'(timeout_err), 32'd1);
        bus.drp_drdy = 1'b1;
        bus.drp_do   = 16'h1230;
        step(1);
        bus.drp_drdy = 1'b0;
        bus.drp_do   = 16'h0000;
        step(2);
        check("late_drdy_ignored", 32'(data_out), 32'h0800);
`ifndef XADC_BCD_OUT_EN
        mode_select = 2'd3; step(2);
        check("status_timeout", 32'(data_out), 32'h810F);
        mode_select = 2'd1;
`endif
        do_sample(16'h4000, 7'h1D);
        check("after_to_raw", 32'(data_out), 32'h0400);

        // Reset during WAIT after 8 samples of ch0
        reset = 1'b1; step(2); reset = 1'b0; step(1);
        ch_select = 2'd0; mode_select = 2'd2;
        for (int r = 0; r < 8; r++) feed_round(16'hFFF0, 16'h0000, 16'h0000, 16'h0000);
        bus.eoc_in = 1'b1;
        step(1);
        bus.eoc_in = 1'b0;
        check("pre_rst_daddr", 32'(bus.drp_daddr), 32'h1C);
        step(1);
        reset = 1'b1;
        step(1);
        check("mid_rst_den", 32'(bus.drp_den), 32'd0);
        check("mid_rst_daddr", 32'(bus.drp_daddr), 32'h1C);
        check("mid_rst_data", 32'(data_out), 32'd0);
        check("mid_rst_valid", 32'(data_valid), 32'd0);
        check("mid_rst_ready", 32'(ch_ready), 32'd0);
        check("mid_rst_timeout", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        bus.drp_drdy = 1'b1;
        bus.drp_do   = 16'hABC0;
        step(1);
        bus.drp_drdy = 1'b0;
        bus.drp_do   = 16'h0000;
        mode_select  = 2'd1;
        step(3);
        check("post_rst_drdy_ignored", 32'(data_out), 32'd0);
        mode_select = 2'd2;
        v_base = valid_cnt;
        for (int r = 0; r < 15; r++) feed_round(16'h8000, 16'h0000, 16'h0000, 16'h0000);
        check("post_rst_ready_15", 32'(ch_ready), 32'd0);
        feed_round(16'h8000, 16'h0000, 16'h0000, 16'h0000);
        check("post_rst_ready_16", 32'(ch_ready[0]), 32'd1);
        check("post_rst_avg", 32'(data_out), 32'h8000);
        check("post_rst_valid", 32'(valid_cnt - v_base), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
